// File: rtl/ram_arb_pkg.sv
// Shared definitions for the eSRAM bridge port arbiter: sequencer states and
// requester ownership codes.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_t;

  localparam logic OWN_RQ0 = 1'b0;
  localparam logic OWN_RQ1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way winner select: a held lock wins first, then a lone
// requester, then the tie rule (fixed rq0 priority or alternate on last owner).
module rr_pick2
  import ram_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  input  logic lock_hold,
  input  logic lock_owner,
  output logic grant_valid,
  output logic grant
);

  logic lock_req;

  assign lock_req = (lock_owner == OWN_RQ1) ? req1 : req0;

  always_comb begin
    grant_valid = req0 | req1;
    grant       = OWN_RQ0;
    if (lock_hold && lock_req) begin
      grant = lock_owner;
    end else if (req0 && !req1) begin
      grant = OWN_RQ0;
    end else if (req1 && !req0) begin
      grant = OWN_RQ1;
    end else if (req0 && req1) begin
      grant = (FIXED_PRIO != 0) ? OWN_RQ0 : ~last_owner;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer sharing the byte-wide eSRAM AHB bridge port;
// runs one transfer through address and data phases and acks the owner.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic              rq0_read,
  input  logic              rq0_write,
  input  logic              rq0_lock,
  output logic              rq0_ack,
  output logic [DATA_W-1:0] rq0_rdata,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  input  logic              rq1_read,
  input  logic              rq1_write,
  input  logic              rq1_lock,
  output logic              rq1_ack,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic [ADDR_W-1:0] maddr,
  output logic [DATA_W-1:0] mwdata,
  output logic              mread,
  output logic              mwrite,
  input  logic [DATA_W-1:0] mrdata,
  input  logic              mready,
  output logic              owner,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              owner_q;
  logic              last_owner_q;
  logic              lock_hold_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              req0, req1, lock_req;
  logic              grant_valid, grant;

  assign req0     = rq0_read | rq0_write;
  assign req1     = rq1_read | rq1_write;
  assign lock_req = (last_owner_q == OWN_RQ1) ? req1 : req0;

  rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_owner  (last_owner_q),
    .lock_hold   (lock_hold_q),
    .lock_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    state_d = state_q;
    mread   = 1'b0;
    mwrite  = 1'b0;
    rq0_ack = 1'b0;
    rq1_ack = 1'b0;
    case (state_q)
      ST_IDLE: if (grant_valid) state_d = ST_ADDR;
      ST_ADDR: begin
        mread  = ~wr_q;
        mwrite = wr_q;
        if (mready) state_d = ST_DATA;
      end
      ST_DATA: if (mready) state_d = ST_ACK;
      ST_ACK: begin
        rq0_ack = (owner_q == OWN_RQ0);
        rq1_ack = (owner_q == OWN_RQ1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      owner_q      <= OWN_RQ0;
      last_owner_q <= OWN_RQ1;
      lock_hold_q  <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          // A lock lapses as soon as its owner stops asking in IDLE.
          if (lock_hold_q && !lock_req) lock_hold_q <= 1'b0;
          if (grant_valid) begin
            owner_q <= grant;
            if (grant == OWN_RQ1) begin
              addr_q  <= rq1_addr;
              wdata_q <= rq1_wdata;
              wr_q    <= rq1_write;
            end else begin
              addr_q  <= rq0_addr;
              wdata_q <= rq0_wdata;
              wr_q    <= rq0_write;
            end
          end
        end
        ST_DATA: begin
          if (mready && !wr_q) begin
            if (owner_q == OWN_RQ1) rdata1_q <= mrdata;
            else                    rdata0_q <= mrdata;
          end
        end
        ST_ACK: begin
          last_owner_q <= owner_q;
          lock_hold_q  <= (owner_q == OWN_RQ1) ? rq1_lock : rq0_lock;
        end
        default: ;
      endcase
    end
  end

  assign maddr     = addr_q;
  assign mwdata    = wdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != ST_IDLE);
  assign rq0_rdata = rdata0_q;
  assign rq1_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: reset checks, single-transfer vector table,
// hand sequences for arbitration/wait/lock/reset, and a randomized bus model.
module tb_ram_port_arbiter;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic [15:0] rq0_addr, rq1_addr, maddr;
  logic [7:0]  rq0_wdata, rq1_wdata, rq0_rdata, rq1_rdata, mwdata, mrdata;
  logic        rq0_read, rq0_write, rq0_lock, rq0_ack;
  logic        rq1_read, rq1_write, rq1_lock, rq1_ack;
  logic        mread, mwrite, mready, owner, busy;

  logic [15:0] f_rq0_addr, f_rq1_addr, f_maddr;
  logic [7:0]  f_rq0_wdata, f_rq1_wdata, f_rq0_rdata, f_rq1_rdata, f_mwdata, f_mrdata;
  logic        f_rq0_read, f_rq0_write, f_rq0_lock, f_rq0_ack;
  logic        f_rq1_read, f_rq1_write, f_rq1_lock, f_rq1_ack;
  logic        f_mread, f_mwrite, f_mready, f_owner, f_busy;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .FIXED_PRIO(0)) dut (
    .Clk(Clk), .Rst(Rst),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_read(rq0_read), .rq0_write(rq0_write),
    .rq0_lock(rq0_lock), .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_read(rq1_read), .rq1_write(rq1_write),
    .rq1_lock(rq1_lock), .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata),
    .maddr(maddr), .mwdata(mwdata), .mread(mread), .mwrite(mwrite),
    .mrdata(mrdata), .mready(mready), .owner(owner), .busy(busy)
  );

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .FIXED_PRIO(1)) dut_f (
    .Clk(Clk), .Rst(Rst),
    .rq0_addr(f_rq0_addr), .rq0_wdata(f_rq0_wdata), .rq0_read(f_rq0_read), .rq0_write(f_rq0_write),
    .rq0_lock(f_rq0_lock), .rq0_ack(f_rq0_ack), .rq0_rdata(f_rq0_rdata),
    .rq1_addr(f_rq1_addr), .rq1_wdata(f_rq1_wdata), .rq1_read(f_rq1_read), .rq1_write(f_rq1_write),
    .rq1_lock(f_rq1_lock), .rq1_ack(f_rq1_ack), .rq1_rdata(f_rq1_rdata),
    .maddr(f_maddr), .mwdata(f_mwdata), .mread(f_mread), .mwrite(f_mwrite),
    .mrdata(f_mrdata), .mready(f_mready), .owner(f_owner), .busy(f_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    rq0_read = 1'b0; rq0_write = 1'b0; rq0_lock = 1'b0; rq0_addr = '0; rq0_wdata = '0;
    rq1_read = 1'b0; rq1_write = 1'b0; rq1_lock = 1'b0; rq1_addr = '0; rq1_wdata = '0;
    mready = 1'b1; mrdata = '0;
  endtask

  task automatic drive_rq(input int n, input logic rd, input logic wr, input logic lk,
                          input logic [15:0] a, input logic [7:0] d);
    if (n == 1) begin
      rq1_read = rd; rq1_write = wr; rq1_lock = lk; rq1_addr = a; rq1_wdata = d;
    end else begin
      rq0_read = rd; rq0_write = wr; rq0_lock = lk; rq0_addr = a; rq0_wdata = d;
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    clr();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  // Randomized traffic against a transaction/bus-level reference: the bench
  // plays both requesters and the bridge memory, predicting every cycle.
  task automatic run_random(input int ncyc);
    int          ph = 0;
    int          op;
    bit          win = 1'b0, last = 1'b1, lk_hold = 1'b0, lk_own = 1'b0, w;
    bit          act[2], done[2], t_rd[2], t_wr[2], t_lk[2];
    logic [15:0] t_addr[2];
    logic [7:0]  t_wd[2];
    logic [7:0]  exp_rd[2];
    logic [7:0]  mem[16];
    bit          cur_wr = 1'b0;
    logic [15:0] cur_addr = '0;
    logic [7:0]  cur_wd = '0;
    for (int n = 0; n < 2; n++) begin
      act[n] = 1'b0; done[n] = 1'b0; exp_rd[n] = '0;
      t_rd[n] = 1'b0; t_wr[n] = 1'b0; t_lk[n] = 1'b0; t_addr[n] = '0; t_wd[n] = '0;
    end
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(posedge Clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (done[n]) begin
          done[n] = 1'b0;
          act[n]  = 1'b0;
        end
        if (!act[n] && $urandom_range(0, 2) == 0) begin
          act[n]    = 1'b1;
          op        = int'($urandom_range(0, 2));
          t_rd[n]   = (op != 1);
          t_wr[n]   = (op != 0);
          t_addr[n] = 16'($urandom);
          t_wd[n]   = 8'($urandom);
          t_lk[n]   = ($urandom_range(0, 3) == 0);
        end
        // The owner's address/data may wander once captured; it must be ignored.
        if ((ph == 1 || ph == 2) && int'(win) == n)
          drive_rq(n, act[n] && t_rd[n], act[n] && t_wr[n], t_lk[n], 16'($urandom), 8'($urandom));
        else
          drive_rq(n, act[n] && t_rd[n], act[n] && t_wr[n], t_lk[n], t_addr[n], t_wd[n]);
      end
      mready = ($urandom_range(0, 3) != 0);
      mrdata = (ph == 2 && !cur_wr) ? mem[cur_addr[3:0]] : 8'($urandom);
      @(negedge Clk);
      case (ph)
        0: begin
          chk("rnd_idle_busy", 32'(busy), 0);
          chk("rnd_idle_bus", 32'(mread | mwrite), 0);
          chk("rnd_idle_ack", 32'({rq1_ack, rq0_ack}), 0);
          if (act[0] || act[1]) begin
            if (lk_hold && act[lk_own]) w = lk_own;
            else if (act[0] && !act[1]) w = 1'b0;
            else if (act[1] && !act[0]) w = 1'b1;
            else w = !last;
            win      = w;
            cur_wr   = t_wr[w];
            cur_addr = t_addr[w];
            cur_wd   = t_wd[w];
            ph       = 1;
          end
          if (lk_hold && !act[lk_own]) lk_hold = 1'b0;
        end
        1: begin
          chk("rnd_addr_owner", 32'(owner), 32'(win));
          chk("rnd_addr_maddr", 32'(maddr), 32'(cur_addr));
          chk("rnd_addr_mwdata", 32'(mwdata), 32'(cur_wd));
          chk("rnd_addr_mwrite", 32'(mwrite), 32'(cur_wr));
          chk("rnd_addr_mread", 32'(mread), 32'(!cur_wr));
          chk("rnd_addr_ack", 32'({rq1_ack, rq0_ack}), 0);
          if (mready) ph = 2;
        end
        2: begin
          chk("rnd_data_bus", 32'(mread | mwrite), 0);
          chk("rnd_data_busy", 32'(busy), 1);
          chk("rnd_data_maddr", 32'(maddr), 32'(cur_addr));
          chk("rnd_data_ack", 32'({rq1_ack, rq0_ack}), 0);
          if (mready) begin
            if (cur_wr) mem[cur_addr[3:0]] = cur_wd;
            else        exp_rd[win] = mem[cur_addr[3:0]];
            ph = 3;
          end
        end
        default: begin
          chk("rnd_ack0", 32'(rq0_ack), 32'(win == 1'b0));
          chk("rnd_ack1", 32'(rq1_ack), 32'(win == 1'b1));
          chk("rnd_rdata0", 32'(rq0_rdata), 32'(exp_rd[0]));
          chk("rnd_rdata1", 32'(rq1_rdata), 32'(exp_rd[1]));
          last    = win;
          lk_hold = t_lk[win];
          lk_own  = win;
          done[win] = 1'b1;
          ph      = 0;
        end
      endcase
    end
  endtask

  typedef struct {
    bit          rq;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mrd;
    logic [7:0]  exp_rdata;
  } vec_t;

  initial begin
    vec_t       vt[8];
    logic [8:0] ms;
    int         k, p, own;

    clr();
    f_rq0_read = 1'b0; f_rq0_write = 1'b0; f_rq0_lock = 1'b0; f_rq0_addr = '0; f_rq0_wdata = '0;
    f_rq1_read = 1'b0; f_rq1_write = 1'b0; f_rq1_lock = 1'b0; f_rq1_addr = '0; f_rq1_wdata = '0;
    f_mready = 1'b1; f_mrdata = '0;

    // Reset values
    repeat (2) @(negedge Clk);
    chk("rst_busy_held", 32'(busy), 0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mread", 32'(mread), 0);
    chk("rst_mwrite", 32'(mwrite), 0);
    chk("rst_acks", 32'({rq1_ack, rq0_ack}), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_maddr", 32'(maddr), 0);
    chk("rst_mwdata", 32'(mwdata), 0);
    chk("rst_rdata0", 32'(rq0_rdata), 0);
    chk("rst_rdata1", 32'(rq1_rdata), 0);

    // Single transfers: {rq, rd, wr, addr, wdata, mrdata, rdata of rq after ack}
    vt[0] = '{1'b0, 1'b1, 1'b0, 16'h0012, 8'h00, 8'hA5, 8'hA5};
    vt[1] = '{1'b1, 1'b1, 1'b0, 16'h0034, 8'h00, 8'h3C, 8'h3C};
    vt[2] = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 8'h5A, 8'h77, 8'hA5};
    vt[3] = '{1'b1, 1'b0, 1'b1, 16'h0000, 8'hC3, 8'h11, 8'h3C};
    vt[4] = '{1'b1, 1'b1, 1'b0, 16'hFFFE, 8'h00, 8'hFF, 8'hFF};
    vt[5] = '{1'b0, 1'b1, 1'b0, 16'h8000, 8'h00, 8'h00, 8'h00};
    vt[6] = '{1'b0, 1'b1, 1'b1, 16'h1234, 8'h99, 8'h66, 8'h00};
    vt[7] = '{1'b1, 1'b1, 1'b0, 16'h00FF, 8'h00, 8'h81, 8'h81};
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge Clk); #1;
        if (c == 0) begin
          clr();
          mrdata = vt[i].mrd;
          drive_rq(int'(vt[i].rq), vt[i].rd, vt[i].wr, 1'b0, vt[i].addr, vt[i].wdata);
        end
        @(negedge Clk);
        case (c)
          0: chk("tv_idle_busy", 32'(busy), 0);
          1: begin
            chk("tv_mread", 32'(mread), 32'(vt[i].rd && !vt[i].wr));
            chk("tv_mwrite", 32'(mwrite), 32'(vt[i].wr));
            chk("tv_maddr", 32'(maddr), 32'(vt[i].addr));
            chk("tv_owner", 32'(owner), 32'(vt[i].rq));
            if (vt[i].wr) chk("tv_mwdata", 32'(mwdata), 32'(vt[i].wdata));
          end
          2: begin
            chk("tv_data_bus", 32'(mread | mwrite), 0);
            chk("tv_data_ack", 32'({rq1_ack, rq0_ack}), 0);
          end
          default: begin
            chk("tv_ack0", 32'(rq0_ack), 32'(!vt[i].rq));
            chk("tv_ack1", 32'(rq1_ack), 32'(vt[i].rq));
            chk("tv_rdata", 32'(vt[i].rq ? rq1_rdata : rq0_rdata), 32'(vt[i].exp_rdata));
          end
        endcase
      end
    end
    @(posedge Clk); #1;
    clr();

    // Round-robin tie from reset: 0,1,0,1
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(posedge Clk); #1;
      if (c == 0) begin
        drive_rq(0, 1'b0, 1'b1, 1'b0, 16'h0100, 8'h11);
        drive_rq(1, 1'b0, 1'b1, 1'b0, 16'h0200, 8'h22);
      end
      @(negedge Clk);
      k = c / 4; p = c % 4; own = k % 2;
      if (p == 1) begin
        chk("tie_owner", 32'(owner), 32'(own));
        chk("tie_maddr", 32'(maddr), (own == 1) ? 32'h0200 : 32'h0100);
        chk("tie_mwrite", 32'(mwrite), 1);
      end else if (p == 3) begin
        chk("tie_ack0", 32'(rq0_ack), 32'(own == 0));
        chk("tie_ack1", 32'(rq1_ack), 32'(own == 1));
      end else begin
        chk("tie_noack", 32'({rq1_ack, rq0_ack}), 0);
      end
    end
    @(posedge Clk); #1;
    clr();

    // Wait states: 3 stalled ADDR cycles, 2 stalled DATA cycles
    ms = 9'b110010000;
    for (int c = 0; c < 9; c++) begin
      @(posedge Clk); #1;
      mready = ms[c];
      if (c == 0) drive_rq(0, 1'b0, 1'b1, 1'b0, 16'h0ABC, 8'h6E);
      @(negedge Clk);
      if (c == 0) chk("ws_idle_busy", 32'(busy), 0);
      if (c >= 1 && c <= 4) chk("ws_addr_mwrite", 32'(mwrite), 1);
      if (c >= 5 && c <= 7) begin
        chk("ws_data_mwrite", 32'(mwrite), 0);
        chk("ws_data_busy", 32'(busy), 1);
      end
      if (c >= 1) begin
        chk("ws_maddr", 32'(maddr), 32'h0ABC);
        chk("ws_mwdata", 32'(mwdata), 32'h6E);
      end
      chk("ws_ack0", 32'(rq0_ack), 32'(c == 8));
    end
    @(posedge Clk); #1;
    clr();

    // Lock: rq1 keeps the port for 3 reads while rq0 waits
    for (int c = 0; c < 16; c++) begin
      @(posedge Clk); #1;
      if (c == 0) begin
        drive_rq(0, 1'b1, 1'b0, 1'b0, 16'h0300, 8'h00);
        drive_rq(1, 1'b1, 1'b0, 1'b1, 16'h0400, 8'h00);
      end
      if (c == 11) rq1_lock = 1'b0;
      mrdata = 8'(8'h40 + c / 4);
      @(negedge Clk);
      k = c / 4; p = c % 4; own = (k < 3) ? 1 : 0;
      if (p == 1) begin
        chk("lock_owner", 32'(owner), 32'(own));
      end else if (p == 3) begin
        chk("lock_ack0", 32'(rq0_ack), 32'(own == 0));
        chk("lock_ack1", 32'(rq1_ack), 32'(own == 1));
        chk("lock_rdata", 32'((own == 1) ? rq1_rdata : rq0_rdata), 32'h40 + 32'(k));
      end else begin
        chk("lock_noack", 32'({rq1_ack, rq0_ack}), 0);
      end
    end
    @(posedge Clk); #1;
    clr();

    // Fixed priority: rq1 starves while rq0 keeps requesting
    for (int c = 0; c < 24; c++) begin
      @(posedge Clk); #1;
      if (c == 0) begin
        f_rq0_read = 1'b1; f_rq0_addr = 16'h0010;
        f_rq1_read = 1'b1; f_rq1_addr = 16'h0020;
      end
      if (c == 20) f_rq0_read = 1'b0;
      @(negedge Clk);
      if (c < 20) begin
        chk("fp_rq1_starved", 32'(f_rq1_ack), 0);
        if (c % 4 == 1) chk("fp_owner", 32'(f_owner), 0);
        if (c % 4 == 3) chk("fp_ack0", 32'(f_rq0_ack), 1);
      end else begin
        chk("fp_ack0_after", 32'(f_rq0_ack), 0);
        chk("fp_ack1_after", 32'(f_rq1_ack), 32'(c == 23));
      end
    end
    @(posedge Clk); #1;
    f_rq1_read = 1'b0;

    // Reset during DATA abandons the transfer; a later request still works
    for (int c = 0; c < 11; c++) begin
      @(posedge Clk); #1;
      case (c)
        0: begin
          drive_rq(0, 1'b1, 1'b0, 1'b0, 16'h0555, 8'h00);
          mrdata = 8'h5E;
          mready = 1'b1;
        end
        2: mready = 1'b0;
        3: clr();
        7: begin
          drive_rq(0, 1'b1, 1'b0, 1'b0, 16'h0556, 8'h00);
          mrdata = 8'h6D;
        end
        default: ;
      endcase
      @(negedge Clk);
      case (c)
        1: chk("rr_mread", 32'(mread), 1);
        2: begin
          chk("rr_data_busy", 32'(busy), 1);
          chk("rr_data_mread", 32'(mread), 0);
          Rst = 1'b1;
          #1;
          chk("rr_async_busy", 32'(busy), 0);
        end
        3: begin
          chk("rr_busy", 32'(busy), 0);
          chk("rr_bus", 32'({mread, mwrite}), 0);
          chk("rr_acks", 32'({rq1_ack, rq0_ack}), 0);
          chk("rr_maddr", 32'(maddr), 0);
          chk("rr_rdata0", 32'(rq0_rdata), 0);
          Rst = 1'b0;
        end
        4, 5, 6: begin
          chk("rr_idle_busy", 32'(busy), 0);
          chk("rr_no_ack", 32'({rq1_ack, rq0_ack}), 0);
        end
        8: begin
          chk("rr_again_mread", 32'(mread), 1);
          chk("rr_again_maddr", 32'(maddr), 32'h0556);
        end
        10: begin
          chk("rr_again_ack", 32'(rq0_ack), 1);
          chk("rr_again_rdata", 32'(rq0_rdata), 32'h6D);
        end
        default: ;
      endcase
    end
    @(posedge Clk); #1;
    clr();

    do_reset();
    run_random(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
